// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Timing core of the stopwatch. It divides the system clock down to a
//   TICK_HZ tick and counts elapsed ticks in a 12-bit binary register. The
//   register saturates at MAX_COUNT. The count feeds a binary-to-BCD converter.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous reset, active-high
//   start_stop  in   1   one-cycle pulse: toggles between running and halted
//   clear       in   1   one-cycle pulse: return to zero, halted
//   bin         out 12   elapsed count, binary, 0..MAX_COUNT
//   running     out  1   high while the counter is in RUN
//   full        out  1   high while the count is saturated (FULL)
//   tick        out  1   high in the cycle whose closing edge commits an increment
module stopwatch_counter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int MAX_COUNT   = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  output logic [11:0] bin,
  output logic        running,
  output logic        full,
  output logic        tick
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_counter: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end
  if (MAX_COUNT > 4095 || MAX_COUNT < 1) begin : g_max_check
    $error("stopwatch_counter: MAX_COUNT must be in 1..4095");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [11:0]   bin_n;
  logic          inc;

  // The increment fires on the last prescaler phase of a RUN cycle.
  assign inc     = (state == RUN) && (presc == PW'(DIV - 1));
  assign tick    = inc;
  assign running = (state == RUN);
  assign full    = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      bin   <= '0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      bin   <= bin_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    bin_n   = bin;
    unique case (state)
      IDLE: begin
        presc_n = '0;
        if (start_stop) state_n = RUN;
      end
      RUN: begin
        if (inc) begin
          presc_n = '0;
          bin_n   = bin + 12'd1;
        end else begin
          presc_n = presc + PW'(1);
        end
        // Reaching saturation outranks a simultaneous stop request; a stop
        // coincident with an ordinary increment still commits that increment.
        if (inc && (bin + 12'd1 == 12'(MAX_COUNT))) state_n = FULL;
        else if (start_stop)                        state_n = HOLD;
      end
      HOLD: begin
        // presc is left untouched so a resume continues the sub-tick phase.
        if (start_stop) state_n = RUN;
      end
      FULL: begin
        presc_n = '0;
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        bin_n   = '0;
      end
    endcase
    if (clear) begin
      state_n = IDLE;
      presc_n = '0;
      bin_n   = '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Bench for stopwatch_counter with DIV=4, MAX_COUNT=5. A behavioural model
//   predicts each cycle's outputs; predictions are queued when stimulus is
//   driven and compared after the clock edge. Directed checks with constant
//   expectations cover the scenario milestones.
module tb_stopwatch_counter;

  localparam int DIV  = 4;
  localparam int MAXC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_stop;
  logic        clear;
  logic [11:0] bin;
  logic        running;
  logic        full;
  logic        tick;

  stopwatch_counter #(
    .CLK_FREQ_HZ (40),
    .TICK_HZ     (10),
    .MAX_COUNT   (MAXC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .bin        (bin),
    .running    (running),
    .full       (full),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int running;
    int full;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: 0 idle, 1 run, 2 hold, 3 full
  int m_st    = 0;
  int m_bin   = 0;
  int m_presc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bin = 0; m_presc = 0;
  endtask

  function automatic int model_tick();
    return (m_st == 1 && m_presc == DIV - 1) ? 1 : 0;
  endfunction

  task automatic model_step(input logic ss, input logic clr);
    int t;
    t = model_tick();
    if (clr) begin
      model_reset();
    end else if (m_st == 0) begin
      if (ss) m_st = 1;
    end else if (m_st == 1) begin
      if (t == 1) begin
        m_bin   = m_bin + 1;
        m_presc = 0;
      end else begin
        m_presc = m_presc + 1;
      end
      if (t == 1 && m_bin == MAXC) m_st = 3;
      else if (ss)                 m_st = 2;
    end else if (m_st == 2) begin
      if (ss) m_st = 1;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic ss, input logic clr);
    exp_t e;
    start_stop = ss;
    clear      = clr;
    #1;
    check("sb_tick", int'(tick), model_tick());
    model_step(ss, clr);
    e.bin = m_bin; e.running = (m_st == 1); e.full = (m_st == 3);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    e = sb_q.pop_front();
    check("sb_bin", int'(bin), e.bin);
    check("sb_running", int'(running), e.running);
    check("sb_full", int'(full), e.full);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0;
    #1;
    check("rst_bin", int'(bin), 0);
    check("rst_tick", int'(tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("idle_bin", int'(bin), 0);
    check("idle_running", int'(running), 0);
    check("idle_full", int'(full), 0);

    // 1. asynchronous reset in the middle of a cycle
    cycle(1'b1, 1'b0);
    idle_cycles(5);
    check("pre_arst_bin", int'(bin), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_bin", int'(bin), 0);
    check("arst_running", int'(running), 0);
    check("arst_full", int'(full), 0);
    check("arst_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 2. start and run 12 cycles
    cycle(1'b1, 1'b0);
    check("t2_running", int'(running), 1);
    for (int i = 1; i <= 12; i++) begin
      check("t2_tick", int'(tick), (i % 4 == 0) ? 1 : 0);
      cycle(1'b0, 1'b0);
      check("t2_bin", int'(bin), i / 4);
    end

    // 3. halt at presc=2, wait, resume: phase is preserved
    idle_cycles(2);
    cycle(1'b1, 1'b0);
    check("t3_hold_running", int'(running), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      check("t3_frozen", int'(bin), 3);
    end
    cycle(1'b1, 1'b0);
    check("t3_resume_bin", int'(bin), 3);
    check("t3_resume_tick", int'(tick), 1);
    cycle(1'b0, 1'b0);
    check("t3_next_inc", int'(bin), 4);

    // 4. saturation, ignored start_stop, clear
    idle_cycles(4);
    check("t4_bin", int'(bin), 5);
    check("t4_full", int'(full), 1);
    check("t4_running", int'(running), 0);
    cycle(1'b1, 1'b0);
    idle_cycles(6);
    check("t4_stuck_bin", int'(bin), 5);
    check("t4_stuck_full", int'(full), 1);
    cycle(1'b0, 1'b1);
    check("t4_clr_bin", int'(bin), 0);
    check("t4_clr_full", int'(full), 0);

    // 5. clear and start_stop together while running at bin=3
    cycle(1'b1, 1'b0);
    idle_cycles(12);
    check("t5_pre_bin", int'(bin), 3);
    cycle(1'b1, 1'b1);
    check("t5_bin", int'(bin), 0);
    check("t5_running", int'(running), 0);
    cycle(1'b0, 1'b0);
    check("t5_stays_idle", int'(bin), 0);

    // 6. start_stop coincident with a tick, then with the final tick
    cycle(1'b1, 1'b0);
    idle_cycles(11);
    check("t6_pre_bin", int'(bin), 2);
    check("t6_pre_tick", int'(tick), 1);
    cycle(1'b1, 1'b0);
    check("t6_hold_bin", int'(bin), 3);
    check("t6_hold_running", int'(running), 0);
    check("t6_hold_full", int'(full), 0);
    cycle(1'b1, 1'b0);
    idle_cycles(7);
    check("t6_pre2_bin", int'(bin), 4);
    check("t6_pre2_tick", int'(tick), 1);
    cycle(1'b1, 1'b0);
    check("t6_full_bin", int'(bin), 5);
    check("t6_full", int'(full), 1);
    check("t6_full_running", int'(running), 0);
    cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
